// File: rtl/mbist_pkg.sv
// Shared types and constants for the March C- MBIST controller: FSM state
// encoding, the march element descriptor and the March C- element table.
package mbist_pkg;

  localparam int NUM_ELEM = 6;
  localparam int RD_LAT   = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // One march element: direction, number of ops per address, and for each op
  // whether it is a write and which background (0 = all zeros, 1 = all ones).
  typedef struct packed {
    logic       dir_down;
    logic [1:0] op_cnt;
    logic       op0_wr;
    logic       op0_bg;
    logic       op1_wr;
    logic       op1_bg;
  } march_elem_t;

  localparam march_elem_t MARCH_C_MINUS [0:NUM_ELEM-1] = '{
    '{1'b0, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0},  // M0 up   (w0)
    '{1'b0, 2'd2, 1'b0, 1'b0, 1'b1, 1'b1},  // M1 up   (r0, w1)
    '{1'b0, 2'd2, 1'b0, 1'b1, 1'b1, 1'b0},  // M2 up   (r1, w0)
    '{1'b1, 2'd2, 1'b0, 1'b0, 1'b1, 1'b1},  // M3 down (r0, w1)
    '{1'b1, 2'd2, 1'b0, 1'b1, 1'b1, 1'b0},  // M4 down (r1, w0)
    '{1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0}   // M5 up   (r0)
  };

  // Bounded table lookup; indices past the last element read as an empty element.
  function automatic march_elem_t march_elem(input logic [2:0] idx);
    march_elem_t e;
    case (idx)
      3'd0:    e = MARCH_C_MINUS[0];
      3'd1:    e = MARCH_C_MINUS[1];
      3'd2:    e = MARCH_C_MINUS[2];
      3'd3:    e = MARCH_C_MINUS[3];
      3'd4:    e = MARCH_C_MINUS[4];
      3'd5:    e = MARCH_C_MINUS[5];
      default: e = '0;
    endcase
    return e;
  endfunction

endpackage

// File: rtl/mbist_march_ctrl_if.sv
// Control/status and memory-port bundle of the MBIST controller.
// master = the controller, slave = test-mode top plus memory under test.
interface mbist_march_ctrl_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int ERR_CNT_W  = 16
);
  logic                  start;
  logic                  busy;
  logic                  done;
  logic                  fail;
  logic [ADDR_WIDTH-1:0] fail_addr;
  logic [DATA_WIDTH-1:0] fail_data;
  logic [ERR_CNT_W-1:0]  err_cnt;
  logic                  mem_write_read;
  logic [ADDR_WIDTH-1:0] mem_address;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport master (
    input  start, mem_rdata,
    output busy, done, fail, fail_addr, fail_data, err_cnt,
           mem_write_read, mem_address, mem_wdata
  );

  modport slave (
    output start, mem_rdata,
    input  busy, done, fail, fail_addr, fail_data, err_cnt,
           mem_write_read, mem_address, mem_wdata
  );
endinterface

// File: rtl/mbist_rd_cmp.sv
// Read-compare path: carries {valid, expected, address} of each issued read
// through two stages to line up with mem_rdata, compares, captures the first
// failure and keeps a saturating error count.
// Optional: MBIST_STOP_ON_FAIL_EN -- a mismatch raises o_stop and discards
// the reads still in flight.
module mbist_rd_cmp #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int ERR_CNT_W  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_clear,
  input  logic                  i_issue_vld,
  input  logic [DATA_WIDTH-1:0] i_issue_exp,
  input  logic [ADDR_WIDTH-1:0] i_issue_addr,
  input  logic [DATA_WIDTH-1:0] i_rdata,
  output logic                  o_stop,
  output logic                  o_fail,
  output logic [ADDR_WIDTH-1:0] o_fail_addr,
  output logic [DATA_WIDTH-1:0] o_fail_data,
  output logic [ERR_CNT_W-1:0]  o_err_cnt
);
  localparam logic [ERR_CNT_W-1:0] ERR_MAX = {ERR_CNT_W{1'b1}};
  localparam logic [ERR_CNT_W-1:0] ERR_ONE = ERR_CNT_W'(1);

  logic                  r_s1_vld, r_s2_vld;
  logic [DATA_WIDTH-1:0] r_s1_exp, r_s2_exp;
  logic [ADDR_WIDTH-1:0] r_s1_addr, r_s2_addr;
  logic                  r_fail;
  logic [ADDR_WIDTH-1:0] r_fail_addr;
  logic [DATA_WIDTH-1:0] r_fail_data;
  logic [ERR_CNT_W-1:0]  r_err_cnt;
  logic                  w_mis;

  assign w_mis = r_s2_vld && (i_rdata != r_s2_exp);

`ifdef MBIST_STOP_ON_FAIL_EN
  assign o_stop = w_mis;
`else
  assign o_stop = 1'b0;
`endif

  // Delay each read's expectation by the memory read latency.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1_vld  <= 1'b0;
      r_s2_vld  <= 1'b0;
      r_s1_exp  <= {DATA_WIDTH{1'b0}};
      r_s2_exp  <= {DATA_WIDTH{1'b0}};
      r_s1_addr <= {ADDR_WIDTH{1'b0}};
      r_s2_addr <= {ADDR_WIDTH{1'b0}};
    end else begin
      if (i_clear || o_stop) begin
        r_s1_vld <= 1'b0;
        r_s2_vld <= 1'b0;
      end else begin
        r_s1_vld <= i_issue_vld;
        r_s2_vld <= r_s1_vld;
      end
      r_s1_exp  <= i_issue_exp;
      r_s2_exp  <= r_s1_exp;
      r_s1_addr <= i_issue_addr;
      r_s2_addr <= r_s1_addr;
    end
  end

  // Record the first mismatch and count all of them, saturating.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_fail      <= 1'b0;
      r_fail_addr <= {ADDR_WIDTH{1'b0}};
      r_fail_data <= {DATA_WIDTH{1'b0}};
      r_err_cnt   <= {ERR_CNT_W{1'b0}};
    end else if (i_clear) begin
      r_fail      <= 1'b0;
      r_fail_addr <= {ADDR_WIDTH{1'b0}};
      r_fail_data <= {DATA_WIDTH{1'b0}};
      r_err_cnt   <= {ERR_CNT_W{1'b0}};
    end else if (w_mis) begin
      if (r_err_cnt != ERR_MAX) begin
        r_err_cnt <= r_err_cnt + ERR_ONE;
      end
      if (!r_fail) begin
        r_fail      <= 1'b1;
        r_fail_addr <= r_s2_addr;
        r_fail_data <= i_rdata;
      end
    end
  end

  assign o_fail      = r_fail;
  assign o_fail_addr = r_fail_addr;
  assign o_fail_data = r_fail_data;
  assign o_err_cnt   = r_err_cnt;

endmodule

// File: rtl/mbist_march_ctrl.sv
// March C- MBIST initiator. Walks element/address/op counters, issues one
// memory op per cycle, presents write data one cycle ahead of its write and
// hands every read to mbist_rd_cmp for checking.
// Optional: MBIST_STOP_ON_FAIL_EN -- end the march at the first mismatch.
module mbist_march_ctrl
  import mbist_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int LAST_ADDR  = 2**ADDR_WIDTH-1,
  parameter int ERR_CNT_W  = 16
) (
  input logic                clk,
  input logic                rst_n,
  mbist_march_ctrl_if.master bus
);
  localparam logic [ADDR_WIDTH-1:0] LAST_A    = ADDR_WIDTH'(LAST_ADDR);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);
  localparam logic [2:0]            LAST_ELEM = 3'(NUM_ELEM - 1);
  localparam logic [1:0]            DRAIN_END = 2'(RD_LAT - 1);

  // Position in the march: element, address and op index within the element.
  typedef struct packed {
    logic [2:0]            elem;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  opi;
  } pos_t;

  function automatic logic op_is_wr(input pos_t p);
    march_elem_t e;
    e = march_elem(p.elem);
    return p.opi ? e.op1_wr : e.op0_wr;
  endfunction

  function automatic logic op_bg(input pos_t p);
    march_elem_t e;
    e = march_elem(p.elem);
    return p.opi ? e.op1_bg : e.op0_bg;
  endfunction

  // True on the last op of the last address of the element.
  function automatic logic elem_end(input pos_t p);
    march_elem_t e;
    e = march_elem(p.elem);
    return (p.addr == (e.dir_down ? {ADDR_WIDTH{1'b0}} : LAST_A)) &&
           (p.opi == (e.op_cnt == 2'd2));
  endfunction

  function automatic logic pos_last(input pos_t p);
    return elem_end(p) && (p.elem == LAST_ELEM);
  endfunction

  // Successor op; an address wrap moves straight into the next element.
  function automatic pos_t next_pos(input pos_t p);
    march_elem_t e, en;
    pos_t        n;
    e = march_elem(p.elem);
    n = p;
    if (!p.opi && (e.op_cnt == 2'd2)) begin
      n.opi = 1'b1;
    end else if (elem_end(p)) begin
      en     = march_elem(p.elem + 3'd1);
      n.elem = p.elem + 3'd1;
      n.opi  = 1'b0;
      n.addr = en.dir_down ? LAST_A : {ADDR_WIDTH{1'b0}};
    end else begin
      n.opi  = 1'b0;
      n.addr = e.dir_down ? (p.addr - ADDR_ONE) : (p.addr + ADDR_ONE);
    end
    return n;
  endfunction

  state_e                r_state;
  pos_t                  r_pos;
  logic                  r_busy, r_done, r_wr, r_rd_vld;
  logic [1:0]            r_drain_cnt;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata, r_exp;

  pos_t                  w_tgt, w_tgt_nxt;
  logic                  w_tgt_wr, w_tgt_last, w_cur_last;
  logic                  w_start_acc, w_issue, w_stop_req, w_stop;
  logic [DATA_WIDTH-1:0] w_tgt_data, w_la_wdata;

  // Next op to issue and the write data that must lead it by one cycle.
  always_comb begin
    w_tgt      = (r_state == ST_IDLE) ? pos_t'(0) : next_pos(r_pos);
    w_tgt_nxt  = next_pos(w_tgt);
    w_tgt_wr   = op_is_wr(w_tgt);
    w_tgt_data = {DATA_WIDTH{op_bg(w_tgt)}};
    w_tgt_last = pos_last(w_tgt);
    w_la_wdata = (!w_tgt_last && op_is_wr(w_tgt_nxt)) ?
                 {DATA_WIDTH{op_bg(w_tgt_nxt)}} : {DATA_WIDTH{1'b0}};
    w_cur_last = pos_last(r_pos);
  end

  assign w_start_acc = (r_state == ST_IDLE) && bus.start;
  assign w_stop      = w_stop_req && ((r_state == ST_RUN) || (r_state == ST_DRAIN));
  assign w_issue     = w_start_acc ||
                       ((r_state == ST_RUN) && !w_stop && !w_cur_last);

  // Control FSM with registered memory-port and status outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_pos       <= pos_t'(0);
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_wr        <= 1'b0;
      r_rd_vld    <= 1'b0;
      r_drain_cnt <= 2'd0;
      r_addr      <= {ADDR_WIDTH{1'b0}};
      r_wdata     <= {DATA_WIDTH{1'b0}};
      r_exp       <= {DATA_WIDTH{1'b0}};
    end else begin
      // Quiet port unless an op is issued this edge; the address holds.
      r_wr     <= 1'b0;
      r_rd_vld <= 1'b0;
      r_wdata  <= {DATA_WIDTH{1'b0}};
      r_done   <= 1'b0;
      if (w_issue) begin
        r_pos    <= w_tgt;
        r_wr     <= w_tgt_wr;
        r_rd_vld <= !w_tgt_wr;
        r_addr   <= w_tgt.addr;
        r_exp    <= w_tgt_data;
        r_wdata  <= w_la_wdata;
      end
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_state <= ST_RUN;
            r_busy  <= 1'b1;
          end
        end
        ST_RUN: begin
          if (w_stop) begin
            r_state <= ST_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else if (w_cur_last) begin
            r_state     <= ST_DRAIN;
            r_drain_cnt <= 2'd0;
          end
        end
        ST_DRAIN: begin
          if (w_stop || (r_drain_cnt == DRAIN_END)) begin
            r_state <= ST_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_drain_cnt <= r_drain_cnt + 2'd1;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  mbist_rd_cmp #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .ERR_CNT_W  (ERR_CNT_W)
  ) u_rd_cmp (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_clear      (w_start_acc),
    .i_issue_vld  (r_rd_vld),
    .i_issue_exp  (r_exp),
    .i_issue_addr (r_addr),
    .i_rdata      (bus.mem_rdata),
    .o_stop       (w_stop_req),
    .o_fail       (bus.fail),
    .o_fail_addr  (bus.fail_addr),
    .o_fail_data  (bus.fail_data),
    .o_err_cnt    (bus.err_cnt)
  );

  assign bus.busy           = r_busy;
  assign bus.done           = r_done;
  assign bus.mem_write_read = r_wr;
  assign bus.mem_address    = r_addr;
  assign bus.mem_wdata      = r_wdata;

endmodule
